// File: rtl/store_align_buffer_pkg.sv
// Shared definitions for the store alignment buffer.
// Size encoding and byte-lane helpers.
package store_align_buffer_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    localparam int BYTE_BITS = 8;

    function automatic int lane_count(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

    localparam int DEF_LANES = lane_count(32);

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane alignment: misalign check,
// byte-enable generation and data lane placement.
module store_lane_align
    import store_align_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [1:0]              in_size,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    misalign,
    output logic [ADDR_WIDTH-1:0]   line_addr,
    output logic [DATA_WIDTH/8-1:0] strobe,
    output logic [DATA_WIDTH-1:0]   data
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int OFFW  = $clog2(LANES);

    size_e            size;
    logic [OFFW-1:0]  off;
    logic [3:0]       nbytes;
    logic             bad;

    assign size   = size_e'(in_size);
    assign off    = in_addr[OFFW-1:0];
    assign nbytes = 4'd1 << in_size;

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            size == SIZE_B: bad = 1'b0;
            size == SIZE_H: bad = in_addr[0];
            size == SIZE_W: bad = |in_addr[1:0];
            size == SIZE_D: bad = (|in_addr[2:0]) || (LANES < 8);
            default:        bad = 1'b0;
        endcase
    end

    assign misalign  = in_valid && bad;
    assign line_addr = {in_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

    // Lane g takes source byte (g - off) when it falls inside the access.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [OFFW-1:0] idx;
        assign idx = OFFW'(g) - off;
        assign strobe[g] = (OFFW'(g) >= off) &&
                           ({{(4-OFFW){1'b0}}, idx} < nbytes);
        assign data[g*8 +: 8] = strobe[g] ?
                                in_data[{idx, 3'b000} +: 8] : 8'h00;
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns incoming stores to bus lanes and
// queues them in FIFO order for issue to the memory bus.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [1:0]                   in_size,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         misalign,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic [DATA_WIDTH/8-1:0]      out_strobe,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] al_addr;
    logic [LANES-1:0]      al_strobe;
    logic [DATA_WIDTH-1:0] al_data;

    logic [ADDR_WIDTH-1:0] mem_addr   [DEPTH];
    logic [LANES-1:0]      mem_strobe [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    store_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_align (
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .in_data   (in_data),
        .misalign  (misalign),
        .line_addr (al_addr),
        .strobe    (al_strobe),
        .data      (al_data)
    );

    assign in_ready  = (count != CW'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready && !misalign;
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]   <= al_addr;
            mem_strobe[wr_ptr] <= al_strobe;
            mem_data[wr_ptr]   <= al_data;
        end
    end

    assign out_addr   = empty ? '0 : mem_addr[rd_ptr];
    assign out_strobe = empty ? '0 : mem_strobe[rd_ptr];
    assign out_data   = empty ? '0 : mem_data[rd_ptr];

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: 32-bit/depth-2 and
// 64-bit/depth-4 instances against a queue model.
module tb_store_align_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  stb;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        int          dw;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        bit          mis;
        logic [31:0] eaddr;
        logic [7:0]  estb;
        logic [63:0] edata;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  iv;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic        out_ready;
    logic        flush;

    logic        r32, m32, ov32, e32;
    logic [31:0] oa32, od32;
    logic [3:0]  os32;
    logic [1:0]  c32;

    logic        r64, m64, ov64, e64;
    logic [31:0] oa64;
    logic [63:0] od64;
    logic [7:0]  os64;
    logic [2:0]  c64;

    logic        mis_a [2];
    logic        rdy_a [2];
    logic        ov_a  [2];
    logic        emp_a [2];
    logic [31:0] oa_a  [2];
    logic [7:0]  os_a  [2];
    logic [63:0] od_a  [2];
    logic [2:0]  cnt_a [2];

    ent_t q0[$];
    ent_t q1[$];
    vec_t tv[12];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    store_align_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (2),
        .ADDR_WIDTH (32)
    ) dut32 (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (iv[0]),
        .in_ready   (r32),
        .in_addr    (addr),
        .in_size    (size),
        .in_data    (data[31:0]),
        .misalign   (m32),
        .out_valid  (ov32),
        .out_ready  (out_ready),
        .out_addr   (oa32),
        .out_strobe (os32),
        .out_data   (od32),
        .flush      (flush),
        .count      (c32),
        .empty      (e32)
    );

    store_align_buffer #(
        .DATA_WIDTH (64),
        .DEPTH      (4),
        .ADDR_WIDTH (32)
    ) dut64 (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (iv[1]),
        .in_ready   (r64),
        .in_addr    (addr),
        .in_size    (size),
        .in_data    (data),
        .misalign   (m64),
        .out_valid  (ov64),
        .out_ready  (out_ready),
        .out_addr   (oa64),
        .out_strobe (os64),
        .out_data   (od64),
        .flush      (flush),
        .count      (c64),
        .empty      (e64)
    );

    assign mis_a[0] = m32;
    assign mis_a[1] = m64;
    assign rdy_a[0] = r32;
    assign rdy_a[1] = r64;
    assign ov_a[0]  = ov32;
    assign ov_a[1]  = ov64;
    assign emp_a[0] = e32;
    assign emp_a[1] = e64;
    assign oa_a[0]  = oa32;
    assign oa_a[1]  = oa64;
    assign os_a[0]  = {4'h0, os32};
    assign os_a[1]  = os64;
    assign od_a[0]  = {32'h0, od32};
    assign od_a[1]  = od64;
    assign cnt_a[0] = {1'b0, c32};
    assign cnt_a[1] = c64;

    task automatic chk(string nm, int k,
                       logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dw%0d: got %h expected %h",
                     nm, (k == 0) ? 32 : 64, act, exp);
        end
    endtask

    function automatic bit model_mis(int dw, logic [31:0] a,
                                     logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        if (nb > dw / 8) return 1'b1;
        return (a % 32'(nb)) != 0;
    endfunction

    function automatic ent_t model_ent(int dw, logic [31:0] a,
                                       logic [1:0] sz,
                                       logic [63:0] d);
        ent_t         e;
        int           nb;
        int           off;
        logic [127:0] m;
        nb     = 1 << sz;
        off    = int'(a % 32'(dw / 8));
        m      = (128'd1 << (8 * nb)) - 128'd1;
        e.addr = a - 32'(off);
        e.stb  = 8'(((1 << nb) - 1) << off);
        e.data = 64'(({64'h0, d} & m) << (8 * off));
        return e;
    endfunction

    // One clock of stimulus checked against the queue model.
    task automatic cycle_check();
        bit   m [2];
        bit   r [2];
        bit   pp [2];
        int   dw [2];
        int   qs;
        int   dep;
        ent_t h;
        dw[0] = 32;
        dw[1] = 64;
        #2;
        for (int k = 0; k < 2; k++) begin
            qs  = (k == 0) ? q0.size() : q1.size();
            dep = (k == 0) ? 2 : 4;
            m[k] = iv[k] && model_mis(dw[k], addr, size);
            r[k] = (qs != dep) && !flush;
            h = '0;
            if (qs != 0) h = (k == 0) ? q0[0] : q1[0];
            chk("misalign", k, 64'(mis_a[k]), 64'(m[k]));
            chk("in_ready", k, 64'(rdy_a[k]), 64'(r[k]));
            chk("out_valid", k, 64'(ov_a[k]), 64'(qs != 0));
            chk("empty", k, 64'(emp_a[k]), 64'(qs == 0));
            chk("count", k, 64'(cnt_a[k]), 64'(qs));
            chk("out_addr", k, 64'(oa_a[k]), 64'(h.addr));
            chk("out_strobe", k, 64'(os_a[k]), 64'(h.stb));
            chk("out_data", k, od_a[k], h.data);
            pp[k] = (qs != 0) && out_ready;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                if (k == 0) q0.delete();
                else        q1.delete();
            end else begin
                if (pp[k]) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
                if (iv[k] && r[k] && !m[k]) begin
                    if (k == 0) q0.push_back(model_ent(32, addr, size, data));
                    else        q1.push_back(model_ent(64, addr, size, data));
                end
            end
        end
        #1;
    endtask

    initial begin
        int k;
        tv[0]  = '{32, 32'h1003, 2'd0, 64'hAB, 1'b0,
                   32'h1000, 8'h08, 64'hAB00_0000};
        tv[1]  = '{32, 32'h2001, 2'd1, 64'h1234, 1'b1,
                   32'h0, 8'h0, 64'h0};
        tv[2]  = '{32, 32'h2000, 2'd2, 64'h1234_5678, 1'b0,
                   32'h2000, 8'h0F, 64'h1234_5678};
        tv[3]  = '{32, 32'h3002, 2'd1, 64'h1234_BEEF, 1'b0,
                   32'h3000, 8'h0C, 64'hBEEF_0000};
        tv[4]  = '{32, 32'h4000, 2'd3, 64'h1, 1'b1,
                   32'h0, 8'h0, 64'h0};
        tv[5]  = '{32, 32'h4002, 2'd2, 64'h1, 1'b1,
                   32'h0, 8'h0, 64'h0};
        tv[6]  = '{64, 32'h10, 2'd3, 64'h1122_3344_5566_7788, 1'b0,
                   32'h10, 8'hFF, 64'h1122_3344_5566_7788};
        tv[7]  = '{64, 32'h14, 2'd2, 64'hCAFE_BABE, 1'b0,
                   32'h10, 8'hF0, 64'hCAFE_BABE_0000_0000};
        tv[8]  = '{64, 32'h2B, 2'd0, 64'hFF_FF5A, 1'b0,
                   32'h28, 8'h08, 64'h5A00_0000};
        tv[9]  = '{64, 32'h14, 2'd3, 64'h1, 1'b1,
                   32'h0, 8'h0, 64'h0};
        tv[10] = '{64, 32'h1E, 2'd1, 64'h77, 1'b0,
                   32'h18, 8'hC0, 64'h0077_0000_0000_0000};
        tv[11] = '{32, 32'h5001, 2'd0, 64'hFFFF_FF33, 1'b0,
                   32'h5000, 8'h02, 64'h3300};

        resetn    = 1'b0;
        iv        = 2'b00;
        addr      = '0;
        size      = '0;
        data      = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        #12;
        for (int j = 0; j < 2; j++) begin
            chk("rst_out_valid", j, 64'(ov_a[j]), 64'd0);
            chk("rst_empty", j, 64'(emp_a[j]), 64'd1);
            chk("rst_count", j, 64'(cnt_a[j]), 64'd0);
            chk("rst_strobe", j, 64'(os_a[j]), 64'd0);
            chk("rst_addr", j, 64'(oa_a[j]), 64'd0);
            chk("rst_data", j, od_a[j], 64'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 0, 64'(r32), 64'd1);
        chk("post_rst_ready", 1, 64'(r64), 64'd1);

        // Single-store alignment vectors.
        for (int i = 0; i < 12; i++) begin
            k         = (tv[i].dw == 64) ? 1 : 0;
            iv        = 2'b00;
            iv[k]     = 1'b1;
            addr      = tv[i].addr;
            size      = tv[i].size;
            data      = tv[i].data;
            out_ready = 1'b0;
            #2;
            chk("tv_misalign", k, 64'(mis_a[k]), 64'(tv[i].mis));
            chk("tv_in_ready", k, 64'(rdy_a[k]), 64'd1);
            @(posedge clk);
            #1 iv = 2'b00;
            #1;
            if (tv[i].mis) begin
                chk("tv_count_rej", k, 64'(cnt_a[k]), 64'd0);
            end else begin
                chk("tv_out_valid", k, 64'(ov_a[k]), 64'd1);
                chk("tv_out_addr", k, 64'(oa_a[k]), 64'(tv[i].eaddr));
                chk("tv_out_strobe", k, 64'(os_a[k]), 64'(tv[i].estb));
                chk("tv_out_data", k, od_a[k], tv[i].edata);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            #1;
            chk("tv_drained", k, 64'(emp_a[k]), 64'd1);
            @(posedge clk);
            #1;
        end

        // Fill to full, third store refused.
        iv   = 2'b01;
        size = 2'd2;
        addr = 32'h100; data = 64'hA; cycle_check();
        addr = 32'h104; data = 64'hB; cycle_check();
        addr = 32'h108; data = 64'hC;
        #1 chk("full_in_ready", 0, 64'(r32), 64'd0);
        chk("full_count", 0, 64'(c32), 64'd2);
        cycle_check();
        out_ready = 1'b1;
        #1 chk("full_ready_ign_out", 0, 64'(r32), 64'd0);
        cycle_check();
        chk("after_pop_count", 0, 64'(c32), 64'd1);
        chk("after_pop_head", 0, 64'(oa32), 64'h104);
        cycle_check();
        chk("push_pop_count", 0, 64'(c32), 64'd1);
        chk("push_pop_head", 0, 64'(oa32), 64'h108);
        iv = 2'b00;
        cycle_check();
        out_ready = 1'b0;

        // Flush with concurrent push and pop.
        iv = 2'b01;
        addr = 32'h200; data = 64'h11; cycle_check();
        addr = 32'h204; data = 64'h22; cycle_check();
        flush = 1'b1; out_ready = 1'b1; addr = 32'h208;
        #1 chk("flush_in_ready", 0, 64'(r32), 64'd0);
        cycle_check();
        flush = 1'b0; iv = 2'b00; out_ready = 1'b0;
        #1;
        chk("flush_count", 0, 64'(c32), 64'd0);
        chk("flush_empty", 0, 64'(e32), 64'd1);
        chk("flush_out_valid", 0, 64'(ov32), 64'd0);

        // Asynchronous reset in the middle of a burst.
        iv = 2'b11; size = 2'd0;
        addr = 32'h300; data = 64'h5; cycle_check();
        addr = 32'h301; data = 64'h6; cycle_check();
        iv = 2'b00;
        #2 resetn = 1'b0;
        #1;
        chk("arst_out_valid", 0, 64'(ov32), 64'd0);
        chk("arst_out_valid", 1, 64'(ov64), 64'd0);
        chk("arst_strobe", 0, 64'(os32), 64'd0);
        chk("arst_count", 1, 64'(c64), 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 resetn = 1'b1;

        // Random traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            iv[0]     = ($urandom_range(0, 9) < 7);
            iv[1]     = ($urandom_range(0, 9) < 7);
            size      = 2'($urandom_range(0, 3));
            addr      = $urandom;
            data      = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 5);
            flush     = ($urandom_range(0, 39) == 0);
            cycle_check();
        end
        iv = 2'b00; flush = 1'b0; out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
